// File: rtl/ready_valid_rr_arbiter.sv
// N:1 ready/valid arbiter: round-robin grant locked for a whole packet,
// feeding a single registered half-buffer output stage.
module ready_valid_rr_arbiter #(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REQ    = 4,
  localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_last,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [ID_WIDTH-1:0]           out_id,
  input  logic                          out_ready
);

  typedef enum logic [0:0] {ARB = 1'b0, LOCK = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ID_WIDTH-1:0]   r_ptr;
  logic [ID_WIDTH-1:0]   w_ptr_nxt;
  logic [ID_WIDTH-1:0]   r_owner;
  logic [ID_WIDTH-1:0]   w_owner_nxt;
  logic [ID_WIDTH-1:0]   w_sel;
  logic [ID_WIDTH-1:0]   w_sel_inc;
  logic                  w_grant_en;
  logic                  w_stage_free;
  logic                  w_accept;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_last;
  logic [ID_WIDTH-1:0]   r_out_id;

  // Requester index base+off, wrapped modulo NUM_REQ (off < NUM_REQ).
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return ID_WIDTH'(sum);
  endfunction

  assign w_stage_free = ~r_out_valid | out_ready;

  // Pick the requester that may talk this cycle: the lock owner, or the first valid from ptr.
  always_comb begin
    w_grant_en = 1'b0;
    w_sel      = r_owner;
    if (r_state == LOCK) begin
      w_grant_en = 1'b1;
      w_sel      = r_owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!w_grant_en && in_valid[wrap_add(r_ptr, k)]) begin
          w_grant_en = 1'b1;
          w_sel      = wrap_add(r_ptr, k);
        end else begin
          w_grant_en = w_grant_en;
        end
      end
    end
  end

  always_comb begin
    in_ready = {NUM_REQ{1'b0}};
    if (reset_n && w_grant_en && w_stage_free) begin
      in_ready[w_sel] = 1'b1;
    end else begin
      in_ready = {NUM_REQ{1'b0}};
    end
  end

  assign w_accept   = |(in_valid & in_ready);
  assign w_sel_data = in_data[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
  assign w_sel_last = in_last[w_sel];
  assign w_sel_inc  = wrap_add(w_sel, 1);

  // Arbitration state only moves on an accepted beat; a last beat releases the lock.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    if (w_accept) begin
      case (r_state)
        ARB: begin
          if (w_sel_last) begin
            w_ptr_nxt = w_sel_inc;
          end else begin
            w_state_nxt = LOCK;
            w_owner_nxt = w_sel;
          end
        end
        LOCK: begin
          if (w_sel_last) begin
            w_state_nxt = ARB;
            w_ptr_nxt   = w_sel_inc;
          end else begin
            w_state_nxt = LOCK;
          end
        end
        default: begin
          w_state_nxt = ARB;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ARB;
      r_ptr   <= {ID_WIDTH{1'b0}};
      r_owner <= {ID_WIDTH{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // Output half buffer: payload is held untouched whenever no new beat is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {DATA_WIDTH{1'b0}};
      r_out_last  <= 1'b0;
      r_out_id    <= {ID_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_last  <= w_sel_last;
      r_out_id    <= w_sel;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_id    = r_out_id;

endmodule

// File: tb/tb_ready_valid_rr_arbiter.sv
// Randomized bench for ready_valid_rr_arbiter against a per-requester packet-queue
// reference model of the round-robin / packet-lock rules.
module tb_ready_valid_rr_arbiter;

  localparam int DW    = 8;
  localparam int NR    = 4;
  localparam int IW    = 2;
  localparam int DEPTH = 1024;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [NR-1:0]    in_valid = '0;
  logic [NR*DW-1:0] in_data = '0;
  logic [NR-1:0]    in_last = '0;
  logic [NR-1:0]    in_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic [IW-1:0]    out_id;
  logic             out_ready = 1'b0;

  ready_valid_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_id(out_id),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pending beats per requester: {last, data}
  logic [8:0] pk_mem [NR][DEPTH];
  int wr_p [NR];
  int rd_p [NR];
  int vprob [NR];
  int rprob = 100;

  // Reference model state
  logic          m_ov;
  logic [DW-1:0] m_data;
  logic          m_last;
  int            m_id;
  int            m_ptr;
  logic          m_lock;
  int            m_owner;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_pkt(input int req, input int base, input int len);
    for (int j = 0; j < len; j++) begin
      pk_mem[req][wr_p[req] % DEPTH] = {(j == len - 1), 8'(base + j)};
      wr_p[req]++;
    end
  endtask

  task automatic model_reset();
    m_ov = 1'b0; m_data = '0; m_last = 1'b0; m_id = 0;
    m_ptr = 0; m_lock = 1'b0; m_owner = 0;
  endtask

  // Who may send now: lock owner, else first valid requester from ptr; only if the stage frees.
  function automatic logic [NR-1:0] model_ready();
    logic [NR-1:0] r;
    logic sf;
    r  = '0;
    sf = !m_ov || out_ready;
    if (m_lock) begin
      if (sf) r[m_owner] = 1'b1;
    end else begin
      for (int k = 0; k < NR; k++) begin
        if (in_valid[(m_ptr + k) % NR]) begin
          if (sf) r[(m_ptr + k) % NR] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic check_outputs(input string pfx);
    check_eq({pfx, "_out_valid"}, 32'(out_valid), 32'(m_ov));
    check_eq({pfx, "_out_data"},  32'(out_data),  32'(m_data));
    check_eq({pfx, "_out_last"},  32'(out_last),  32'(m_last));
    check_eq({pfx, "_out_id"},    32'(out_id),    32'(m_id));
  endtask

  task automatic step();
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] acc;
    logic [8:0]    head;
    int            w;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      head = pk_mem[i][rd_p[i] % DEPTH];
      in_valid[i] = (wr_p[i] > rd_p[i]) && ($urandom_range(99) < vprob[i]);
      in_data[i*DW +: DW] = in_valid[i] ? head[7:0] : 8'($urandom);
      in_last[i] = in_valid[i] ? head[8] : 1'($urandom);
    end
    out_ready = ($urandom_range(99) < rprob);
    #1;
    exp_rdy = model_ready();
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    check_outputs("cyc");
    @(posedge clk);
    acc = in_valid & exp_rdy;
    if (acc != '0) begin
      w = 0;
      for (int i = 0; i < NR; i++) if (acc[i]) w = i;
      head = pk_mem[w][rd_p[w] % DEPTH];
      rd_p[w]++;
      m_ov = 1'b1; m_data = head[7:0]; m_last = head[8]; m_id = w;
      if (m_lock) begin
        if (head[8]) begin
          m_lock = 1'b0;
          m_ptr  = (m_owner + 1) % NR;
        end
      end else if (head[8]) begin
        m_ptr = (w + 1) % NR;
      end else begin
        m_lock  = 1'b1;
        m_owner = w;
      end
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic set_vprob(input int p);
    for (int i = 0; i < NR; i++) vprob[i] = p;
  endtask

  // Reset asserted mid-cycle: outputs must clear without waiting for a clock edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_in_ready", 32'(in_ready), 32'h0);
    check_outputs("rst");
    for (int i = 0; i < NR; i++) rd_p[i] = wr_p[i];
    in_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int left;
    for (int i = 0; i < NR; i++) begin
      wr_p[i] = 0; rd_p[i] = 0; vprob[i] = 100;
    end
    model_reset();
    async_reset();

    // 4-beat packet from req0 at full throughput
    rprob = 100; set_vprob(100);
    push_pkt(0, 8'hA0, 4);
    run(7);

    // single-beat packets from all requesters, req0 refilled
    push_pkt(0, 8'h10, 1); push_pkt(1, 8'h20, 1); push_pkt(2, 8'h30, 1); push_pkt(3, 8'h40, 1);
    push_pkt(0, 8'h11, 1);
    run(8);

    // req0 3-beat packet contending with req1
    push_pkt(0, 8'h50, 3); push_pkt(1, 8'h60, 2);
    run(8);

    // downstream stall for 5 cycles, then release
    push_pkt(1, 8'h70, 2); push_pkt(3, 8'h80, 1);
    rprob = 0; run(5);
    rprob = 100; run(6);

    // lock owner bubbles while req2 waits
    push_pkt(0, 8'h90, 4); push_pkt(2, 8'hC0, 1);
    run(2);
    vprob[0] = 0; run(2);
    vprob[0] = 100; run(6);

    // reset in the middle of a req1 packet, then both req0 and req1 request
    push_pkt(1, 8'hD0, 4);
    run(3);
    async_reset();
    push_pkt(0, 8'hE0, 1); push_pkt(1, 8'hF0, 1);
    run(5);

    // random traffic with random backpressure and valid gaps
    set_vprob(75); rprob = 65;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (wr_p[i] == rd_p[i] && $urandom_range(3) == 0)
          push_pkt(i, int'($urandom_range(255)), int'($urandom_range(4, 1)));
      end
      step();
    end

    // drain everything that is still queued
    set_vprob(100); rprob = 100;
    run(40);
    left = 0;
    for (int i = 0; i < NR; i++) left += wr_p[i] - rd_p[i];
    check_eq("drain_left", 32'(left), 32'h0);
    check_outputs("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
